mult_div_unit: RTL

//   Iterative multiply/divide unit in the execute stage, beside the ALU; both take the same OP1/OP2.

---
 rtl/mult_div_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Purpose  : Radix-2 iterative MULT/MULTU/DIV/DIVU into HI/LO with MTHI/MTLO.
// Revision : 1.0  initial release
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] ITER_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [CW-1:0]      iter_q, iter_d;
    logic [WIDTH-1:0]   op1_q, op1_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               w_signed;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [WIDTH:0]     w_msum;
    logic [WIDTH:0]     w_trial, w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_mult_next, w_div_next, w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem;

    always_comb begin
        w_signed = ~op[0];
        w_a_mag  = (w_signed && op1[WIDTH-1]) ? -op1 : op1;
        w_b_mag  = (w_signed && op2[WIDTH-1]) ? -op2 : op2;

        // Shift-add: low half holds the remaining multiplier bits.
        w_msum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + ({(WIDTH+1){acc_q[0]}} & {1'b0, opb_q});
        w_mult_next = {w_msum, acc_q[WIDTH-1:1]};

        // Restoring divide: shift in next dividend bit, subtract if it fits.
        w_trial    = acc_q[2*WIDTH-1:WIDTH-1];
        w_diff     = w_trial - {1'b0, opb_q};
        w_ge       = ~w_diff[WIDTH];
        w_div_next = {(w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0]),
                      acc_q[WIDTH-2:0], w_ge};

        w_prod = neg_res_q ? -acc_q : acc_q;
        w_quo  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        w_rem  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        iter_d    = iter_q;
        op1_d     = op1_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_CALC;
                    is_div_d  = op[1];
                    neg_res_d = w_signed & (op1[WIDTH-1] ^ op2[WIDTH-1]);
                    neg_rem_d = w_signed & op1[WIDTH-1];
                    iter_d    = '0;
                    op1_d     = op1;
                    opb_d     = w_b_mag;
                    acc_d     = {{WIDTH{1'b0}}, w_a_mag};
                    busy_d    = 1'b1;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_CALC: begin
                acc_d  = is_div_q ? w_div_next : w_mult_next;
                iter_d = iter_q + 1'b1;
                if (iter_q == ITER_LAST) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = w_prod[2*WIDTH-1:WIDTH];
                    lo_d = w_prod[WIDTH-1:0];
                end else if (opb_q == '0) begin
                    // Divide by zero reports the untouched dividend bits.
                    hi_d = op1_q;
                    lo_d = '1;
                end else begin
                    hi_d = w_rem;
                    lo_d = w_quo;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            iter_q    <= '0;
            op1_q     <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            iter_q    <= iter_d;
            op1_q     <= op1_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire
